// File: rtl/dram2videoaxis_pkg.sv
// rtl/dram2videoaxis_pkg.sv - shared constants, FSM state type and field helpers for dram2videoaxis
package dram2videoaxis_pkg;

  localparam int BURST_LEN     = 64;
  localparam int FIFO_DEPTH    = 128;
  localparam int CTRL_LEN_MSB  = 39;
  localparam int CTRL_LEN_LSB  = 32;
  localparam int CTRL_ADDR_MSB = 31;
  localparam int CTRL_ADDR_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_t;

  function automatic logic [39:0] pack_ctrl(input logic [7:0] len, input logic [31:0] addr);
    logic [39:0] c;
    c = '0;
    c[CTRL_LEN_MSB:CTRL_LEN_LSB]   = len;
    c[CTRL_ADDR_MSB:CTRL_ADDR_LSB] = addr;
    return c;
  endfunction

  // Memory word byte order is {R, B, G, x}; the video stream wants {R, G, B}.
  function automatic logic [23:0] unpack_pixel(input logic [31:0] w);
    return {w[31:24], w[15:8], w[23:16]};
  endfunction

endpackage

// File: rtl/dram2videoaxis_if.sv
// rtl/dram2videoaxis_if.sv - DRAM read request/data and video stream signals of dram2videoaxis
interface dram2videoaxis_if;

  logic [39:0] ctrl_out;
  logic        ctrl_we;
  logic        ctrl_ready;
  logic [31:0] data_in;
  logic        data_valid;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tuser;
  logic        m_axis_tlast;

  modport master (
    output ctrl_out, ctrl_we, m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast,
    input  ctrl_ready, data_in, data_valid, m_axis_tready
  );

  modport slave (
    input  ctrl_out, ctrl_we, m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast,
    output ctrl_ready, data_in, data_valid, m_axis_tready
  );

endinterface

// File: rtl/sync_fifo_w32d128.sv
// rtl/sync_fifo_w32d128.sv - 32-bit x 128 synchronous FIFO with registered head word and occupancy count
module sync_fifo_w32d128
  import dram2videoaxis_pkg::*;
(
  input  logic        vid_clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic [7:0]  count,
  output logic        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    mem_count;
  logic          full, wr_ok, pop, load, from_mem, bypass, mem_wr;

  // The head register counts as one stored word, so the array never holds more than 127.
  assign count    = mem_count + {7'd0, rd_valid};
  assign full     = (count == 8'(FIFO_DEPTH));
  assign overflow = wr_en && full;
  assign wr_ok    = wr_en && !full;
  assign pop      = rd_en && rd_valid;
  assign load     = !rd_valid || pop;
  assign from_mem = load && (mem_count != 8'd0);
  assign bypass   = load && (mem_count == 8'd0) && wr_ok;
  assign mem_wr   = wr_ok && !bypass;

  always_ff @(posedge vid_clk) begin
    if (mem_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge vid_clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      if (mem_wr) wr_ptr <= wr_ptr + 1'b1;
      if (from_mem) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end else if (bypass) begin
        rd_data <= wr_data;
      end
      if (load) rd_valid <= from_mem || bypass;
      mem_count <= mem_count + {7'd0, mem_wr} - {7'd0, from_mem};
    end
  end

endmodule

// File: rtl/dram2videoaxis.sv
// rtl/dram2videoaxis.sv - issues line-bounded DRAM burst reads for a frame and streams the pixels as video
module dram2videoaxis
  import dram2videoaxis_pkg::*;
#(
  parameter int          WIDTH     = 1600,
  parameter int          HEIGHT    = 1200,
  parameter logic [31:0] BASE_ADDR = 32'h0
)(
  input  logic             vid_clk,
  input  logic             rst,
  dram2videoaxis_if.master bus,
  input  logic             play_sig,
  output logic             play_rtn,
  output logic             err_ovf
);

  localparam logic [7:0] FIRST_LEN = (WIDTH >= BURST_LEN) ? 8'(BURST_LEN) : 8'(WIDTH);

  state_t      state;
  logic [11:0] req_x, req_y, out_x, out_y;
  logic [8:0]  outstanding;
  logic [11:0] remain, next_x;
  logic [7:0]  cur_len;
  logic [31:0] pix_off, cur_addr;
  logic [31:0] head;
  logic [7:0]  fifo_count;
  logic        head_valid, fifo_ovf;
  logic        accept, line_end, last_req, px_fire, frame_end, room;

  assign remain    = 12'(WIDTH) - req_x;
  assign cur_len   = (remain >= 12'(BURST_LEN)) ? 8'(BURST_LEN) : remain[7:0];
  assign pix_off   = 32'(req_y) * 32'(WIDTH) + 32'(req_x);
  assign cur_addr  = BASE_ADDR + (pix_off << 2);
  assign next_x    = req_x + 12'(cur_len);
  assign line_end  = (next_x == 12'(WIDTH));
  assign last_req  = line_end && (req_y == 12'(HEIGHT - 1));
  assign accept    = bus.ctrl_we && bus.ctrl_ready;
  assign px_fire   = head_valid && bus.m_axis_tready;
  assign frame_end = px_fire && (out_x == 12'(WIDTH - 1)) && (out_y == 12'(HEIGHT - 1));
  // Only ask for another burst when everything already owed still fits beside it.
  assign room      = ({2'b00, fifo_count} + {1'b0, outstanding}) <= 10'(FIFO_DEPTH - BURST_LEN);

  sync_fifo_w32d128 u_fifo (
    .vid_clk  (vid_clk),
    .rst      (rst),
    .wr_en    (bus.data_valid),
    .wr_data  (bus.data_in),
    .rd_en    (px_fire),
    .rd_data  (head),
    .rd_valid (head_valid),
    .count    (fifo_count),
    .overflow (fifo_ovf)
  );

  assign bus.m_axis_tvalid = head_valid;
  assign bus.m_axis_tdata  = unpack_pixel(head);
  assign bus.m_axis_tuser  = head_valid && (out_x == 12'd0) && (out_y == 12'd0);
  assign bus.m_axis_tlast  = head_valid && (out_x == 12'(WIDTH - 1));

  always_ff @(posedge vid_clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      bus.ctrl_we <= 1'b0;
      bus.ctrl_out <= '0;
      req_x       <= '0;
      req_y       <= '0;
      play_rtn    <= 1'b0;
    end else begin
      if (frame_end) play_rtn <= play_sig;
      case (state)
        ST_IDLE: begin
          req_x <= '0;
          req_y <= '0;
          if (play_rtn) begin
            state        <= ST_REQ;
            bus.ctrl_we  <= 1'b1;
            bus.ctrl_out <= pack_ctrl(FIRST_LEN, BASE_ADDR);
          end else begin
            play_rtn <= play_sig;
          end
        end
        ST_REQ: begin
          if (accept) begin
            bus.ctrl_we <= 1'b0;
            if (line_end) begin
              req_x <= '0;
              req_y <= req_y + 12'd1;
            end else begin
              req_x <= next_x;
            end
            state <= last_req ? ST_DONE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (room) begin
            state        <= ST_REQ;
            bus.ctrl_we  <= 1'b1;
            bus.ctrl_out <= pack_ctrl(cur_len, cur_addr);
          end
        end
        ST_DONE: begin
          if (frame_end) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge vid_clk) begin
    if (rst) begin
      outstanding <= '0;
      out_x       <= '0;
      out_y       <= '0;
      err_ovf     <= 1'b0;
    end else begin
      outstanding <= outstanding
                   + (accept ? {1'b0, bus.ctrl_out[CTRL_LEN_MSB:CTRL_LEN_LSB]} : 9'd0)
                   - {8'd0, bus.data_valid};
      if (fifo_ovf) err_ovf <= 1'b1;
      if (px_fire) begin
        if (out_x == 12'(WIDTH - 1)) begin
          out_x <= '0;
          out_y <= (out_y == 12'(HEIGHT - 1)) ? 12'd0 : out_y + 12'd1;
        end else begin
          out_x <= out_x + 12'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dram2videoaxis.sv
// tb/tb_dram2videoaxis.sv - self-checking bench for dram2videoaxis with a DRAM responder and frame scoreboard
module tb_dram2videoaxis;

  localparam int          W    = 100;
  localparam int          H    = 2;
  localparam int          NPIX = W * H;
  localparam logic [31:0] BASE = 32'h1000;

  logic vid_clk = 1'b0;
  logic rst = 1'b1;
  logic play_sig = 1'b0;
  logic play_rtn, err_ovf;

  dram2videoaxis_if bus();

  dram2videoaxis #(.WIDTH(W), .HEIGHT(H), .BASE_ADDR(BASE)) dut (
    .vid_clk  (vid_clk),
    .rst      (rst),
    .bus      (bus.master),
    .play_sig (play_sig),
    .play_rtn (play_rtn),
    .err_ovf  (err_ovf)
  );

  always #5 vid_clk = ~vid_clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] pixel_mem [NPIX];
  logic [7:0]  exp_len[$];
  logic [31:0] exp_addr[$];
  int          dram_q[$];
  int          pix = 0, req_idx = 0, buffered = 0, tready_low = 0;
  bit          rand_mode = 0;
  bit          prev_stall = 0, prev_req_wait = 0;
  logic [23:0] prev_tdata;
  logic        prev_tuser, prev_tlast;
  logic [39:0] prev_ctrl;
  logic        last_play = 1'b0;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ctrl_we"},  bus.ctrl_we, 0);
    chk({tag, "_ctrl_out"}, bus.ctrl_out, 0);
    chk({tag, "_tvalid"},   bus.m_axis_tvalid, 0);
    chk({tag, "_tuser"},    bus.m_axis_tuser, 0);
    chk({tag, "_tlast"},    bus.m_axis_tlast, 0);
    chk({tag, "_tdata"},    bus.m_axis_tdata, 0);
    chk({tag, "_play_rtn"}, play_rtn, 0);
    chk({tag, "_err_ovf"},  err_ovf, 0);
  endtask

  // One cycle: verify holds, pick new inputs, then score the handshakes that the next edge completes.
  task automatic tick();
    int          sum_before, idx;
    logic [31:0] w, a;
    @(negedge vid_clk);
    if (prev_stall) begin
      chk("stall_tvalid", bus.m_axis_tvalid, 1);
      chk("stall_tdata",  bus.m_axis_tdata, prev_tdata);
      chk("stall_tuser",  bus.m_axis_tuser, prev_tuser);
      chk("stall_tlast",  bus.m_axis_tlast, prev_tlast);
    end
    if (prev_req_wait) begin
      chk("req_hold_we",  bus.ctrl_we, 1);
      chk("req_hold_out", bus.ctrl_out, prev_ctrl);
    end
    sum_before = dram_q.size() + buffered;

    if (tready_low > 0) begin
      bus.m_axis_tready = 1'b0;
      tready_low--;
    end else begin
      bus.m_axis_tready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    bus.ctrl_ready = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (dram_q.size() > 0 && (!rand_mode || $urandom_range(0, 3) != 0)) begin
      idx = dram_q.pop_front();
      bus.data_valid = 1'b1;
      bus.data_in    = pixel_mem[idx];
      buffered++;
    end else begin
      bus.data_valid = 1'b0;
      bus.data_in    = $urandom;
    end

    if (bus.ctrl_we && bus.ctrl_ready) begin
      chk("req_room", 40'(sum_before <= 64), 1);
      chk($sformatf("req%0d", req_idx), bus.ctrl_out,
          {exp_len[req_idx % exp_len.size()], exp_addr[req_idx % exp_addr.size()]});
      for (int i = 0; i < int'(bus.ctrl_out[39:32]); i++) begin
        a = ((bus.ctrl_out[31:0] - BASE) >> 2) + 32'(i);
        dram_q.push_back(int'(a % 32'(NPIX)));
      end
      req_idx++;
    end

    if (bus.m_axis_tvalid && bus.m_axis_tready) begin
      w = pixel_mem[pix % NPIX];
      chk($sformatf("tdata_p%0d", pix), bus.m_axis_tdata, {w[31:24], w[15:8], w[23:16]});
      chk($sformatf("tuser_p%0d", pix), bus.m_axis_tuser, (pix % NPIX) == 0);
      chk($sformatf("tlast_p%0d", pix), bus.m_axis_tlast, (pix % W) == W - 1);
      if (pix == 0) chk("px0_tdata_const", bus.m_axis_tdata, 24'hAACCBB);
      if (pix == NPIX - 1) last_play = play_rtn;
      pix++;
      buffered--;
    end

    prev_stall    = bus.m_axis_tvalid && !bus.m_axis_tready;
    prev_tdata    = bus.m_axis_tdata;
    prev_tuser    = bus.m_axis_tuser;
    prev_tlast    = bus.m_axis_tlast;
    prev_req_wait = bus.ctrl_we && !bus.ctrl_ready;
    prev_ctrl     = bus.ctrl_out;
  endtask

  task automatic run_until(input int target, input string tag);
    int n;
    n = 0;
    while (pix < target && n < 4000) begin
      tick();
      n++;
    end
    chk({tag, "_in_budget"}, 40'(pix >= target), 1);
  endtask

  task automatic start_frame();
    pix       = 0;
    req_idx   = 0;
    last_play = 1'b0;
  endtask

  task automatic end_frame(input string tag);
    chk({tag, "_play_at_last_px"}, last_play, 1);
    repeat (30) tick();
    chk({tag, "_play_rtn_fell"}, play_rtn, 0);
    chk({tag, "_req_count"}, req_idx, 4);
    chk({tag, "_pixel_count"}, pix, NPIX);
    chk({tag, "_tvalid_idle"}, bus.m_axis_tvalid, 0);
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) pixel_mem[i] = $urandom;
    pixel_mem[0] = 32'hAABBCCFF;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x += 64) begin
        exp_len.push_back(8'((x + 64 <= W) ? 64 : W - x));
        exp_addr.push_back(BASE + 32'((y * W + x) * 4));
      end
    bus.ctrl_ready    = 1'b0;
    bus.data_in       = '0;
    bus.data_valid    = 1'b0;
    bus.m_axis_tready = 1'b0;

    repeat (3) @(negedge vid_clk);
    check_reset("por");
    rst = 1'b0;

    // Frame 1: single-cycle play pulse, ready everywhere.
    rand_mode = 0;
    start_frame();
    play_sig = 1'b1;
    tick();
    play_sig = 1'b0;
    run_until(NPIX, "f1");
    end_frame("f1");

    // Frame 2: random backpressure, a 10-cycle stall mid-line, play dropped mid-frame.
    rand_mode = 1;
    start_frame();
    play_sig = 1'b1;
    run_until(30, "f2a");
    tready_low = 10;
    run_until(W, "f2b");
    play_sig = 1'b0;
    run_until(NPIX, "f2c");
    end_frame("f2");

    // Frame 3: abandoned by reset at pixel 50.
    start_frame();
    play_sig = 1'b1;
    tick();
    play_sig = 1'b0;
    run_until(50, "f3");
    @(negedge vid_clk);
    rst = 1'b1;
    bus.data_valid    = 1'b0;
    bus.ctrl_ready    = 1'b0;
    bus.m_axis_tready = 1'b0;
    @(negedge vid_clk);
    check_reset("midrst");
    rst = 1'b0;
    dram_q.delete();
    buffered      = 0;
    prev_stall    = 0;
    prev_req_wait = 0;

    // Frame 4: restarts from the base address.
    start_frame();
    play_sig = 1'b1;
    tick();
    play_sig = 1'b0;
    run_until(NPIX, "f4");
    end_frame("f4");

    // Overflow: 129 unsolicited words with the stream stalled.
    bus.m_axis_tready = 1'b0;
    bus.ctrl_ready    = 1'b0;
    for (int i = 0; i < 128; i++) begin
      @(negedge vid_clk);
      bus.data_valid = 1'b1;
      bus.data_in    = $urandom;
    end
    @(negedge vid_clk);
    chk("ovf_clear_at_128", err_ovf, 0);
    chk("ovf_tvalid", bus.m_axis_tvalid, 1);
    @(negedge vid_clk);
    bus.data_valid = 1'b0;
    chk("ovf_set", err_ovf, 1);
    repeat (10) @(negedge vid_clk);
    chk("ovf_sticky", err_ovf, 1);
    rst = 1'b1;
    @(negedge vid_clk);
    check_reset("ovfrst");
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
